// File: rtl/cpu_pkg.sv
// Shared types for the single-cycle ARMv4-subset CPU: ALU controls, op fields,
// condition codes and NZCV bit positions, plus the condition-evaluation helper.
package cpu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctrl_e;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'ha, COND_LT = 4'hb,
        COND_GT = 4'hc, COND_LE = 4'hd, COND_AL = 4'he, COND_NV = 4'hf
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // The reserved 1111 condition never passes, so such words retire as NOPs.
    function automatic logic cond_pass(input cond_e cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        case (cond)
            COND_EQ: cond_pass = z;
            COND_NE: cond_pass = !z;
            COND_CS: cond_pass = c;
            COND_CC: cond_pass = !c;
            COND_MI: cond_pass = n;
            COND_PL: cond_pass = !n;
            COND_VS: cond_pass = v;
            COND_VC: cond_pass = !v;
            COND_HI: cond_pass = c && !z;
            COND_LS: cond_pass = !c || z;
            COND_GE: cond_pass = (n == v);
            COND_LT: cond_pass = (n != v);
            COND_GT: cond_pass = !z && (n == v);
            COND_LE: cond_pass = z || (n != v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational 32-bit ALU: ADD/SUB/AND/ORR with NZCV generation.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_ctrl_e   ctrl,
    output logic [31:0] result,
    output logic [3:0]  nzcv
);

    logic        is_sub;
    logic        arith;
    logic [31:0] b_eff;
    logic [32:0] sum;

    always_comb begin
        is_sub = (ctrl == ALU_SUB);
        arith  = (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
        // Subtraction as a + ~b + 1 so that C is the ARM "no borrow" carry.
        b_eff  = is_sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {32'd0, is_sub};

        case (ctrl)
            ALU_AND: result = a & b;
            ALU_ORR: result = a | b;
            default: result = sum[31:0];
        endcase

        nzcv         = '0;
        nzcv[FLAG_N] = result[31];
        nzcv[FLAG_Z] = (result == 32'd0);
        nzcv[FLAG_C] = arith && sum[32];
        nzcv[FLAG_V] = arith && (a[31] == b_eff[31]) && (sum[31] != a[31]);
    end

endmodule

// File: rtl/cpu_top.sv
// Single-cycle ARMv4-subset CPU with instruction ROM and data RAM.
// Define CPU_TOP_BYTE_ACCESS_EN to enable LDRB/STRB via the B bit.
module cpu_top
    import cpu_pkg::*;
#(
    parameter string MEMFILE    = "memfile.dat",
    parameter int    IMEM_WORDS = 64,
    parameter int    DMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] WriteData,
    output logic [31:0] DataAdr,
    output logic        MemWrite
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] rf   [15];

    logic [31:0]        pc, pc_plus4, pc_plus8, instr;
    logic [3:0]         nzcv, alu_flags;
    logic [1:0]         op;
    logic [3:0]         rn, rd, rm, ra1, ra2;
    logic               dp_ok, mem_ok, br_ok, cond_ok, active;
    logic               is_load, reg_write, flag_write, take_branch;
    logic [31:0]        rd1, rd2, src_b, alu_result, mem_rdata, result;
    logic [63:0]        imm_dbl;
    logic [31:0]        imm_rot;
    logic signed [31:0] br_offset;
    alu_ctrl_e          alu_ctrl;

    assign instr    = imem[pc[IAW+1:2]];
    assign pc_plus4 = pc + 32'd4;
    assign pc_plus8 = pc + 32'd8;

    assign op = instr[27:26];
    assign rn = instr[19:16];
    assign rd = instr[15:12];
    assign rm = instr[3:0];

    always_comb begin
        dp_ok   = (op == OP_DP) && (instr[25] || (instr[11:4] == 8'h00)) &&
                  (instr[24:21] inside {CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR});
        // Only pre-indexed immediate-offset transfers without writeback.
        mem_ok  = (op == OP_MEM) && !instr[25] && instr[24] && !instr[21];
        br_ok   = (op == OP_BR) && instr[25];
        cond_ok = cond_pass(cond_e'(instr[31:28]), nzcv);
        active  = reset && cond_ok;
    end

    assign ra1 = br_ok ? 4'd15 : rn;
    assign ra2 = mem_ok ? rd : rm;
    assign rd1 = (ra1 == 4'd15) ? pc_plus8 : rf[ra1];
    assign rd2 = (ra2 == 4'd15) ? pc_plus8 : rf[ra2];

    assign imm_dbl   = {24'd0, instr[7:0], 24'd0, instr[7:0]} >> {instr[11:8], 1'b0};
    assign imm_rot   = imm_dbl[31:0];
    assign br_offset = {{6{instr[23]}}, instr[23:0], 2'b00};

    always_comb begin
        src_b    = rd2;
        alu_ctrl = ALU_ADD;
        if (br_ok) begin
            src_b = br_offset;
        end else if (mem_ok) begin
            src_b    = {20'd0, instr[11:0]};
            alu_ctrl = instr[23] ? ALU_ADD : ALU_SUB;
        end else begin
            if (instr[25]) src_b = imm_rot;
            case (instr[24:21])
                CMD_SUB: alu_ctrl = ALU_SUB;
                CMD_AND: alu_ctrl = ALU_AND;
                CMD_ORR: alu_ctrl = ALU_ORR;
                default: alu_ctrl = ALU_ADD;
            endcase
        end
    end

    cpu_alu u_alu (
        .a      (rd1),
        .b      (src_b),
        .ctrl   (alu_ctrl),
        .result (alu_result),
        .nzcv   (alu_flags)
    );

    assign is_load     = mem_ok && instr[20];
    assign reg_write   = active && (rd != 4'd15) && (dp_ok || is_load);
    assign flag_write  = active && dp_ok && instr[20];
    assign take_branch = active && br_ok;

    assign DataAdr   = alu_result;
    assign WriteData = rd2;
    assign MemWrite  = active && mem_ok && !instr[20];
    assign result    = is_load ? mem_rdata : alu_result;

`ifdef CPU_TOP_BYTE_ACCESS_EN
    logic [31:0] word_rd, lane_wdata;
    logic [7:0]  byte_rd;
    logic [3:0]  byte_en;

    assign word_rd    = dmem[DataAdr[DAW+1:2]];
    assign byte_rd    = word_rd[{DataAdr[1:0], 3'b000} +: 8];
    assign mem_rdata  = instr[22] ? {24'd0, byte_rd} : word_rd;
    assign byte_en    = instr[22] ? (4'b0001 << DataAdr[1:0]) : 4'b1111;
    assign lane_wdata = instr[22] ? {4{WriteData[7:0]}} : WriteData;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (MemWrite && byte_en[i]) dmem[DataAdr[DAW+1:2]][8*i +: 8] <= lane_wdata[8*i +: 8];
        end
    end
`else
    assign mem_rdata = dmem[DataAdr[DAW+1:2]];

    always_ff @(posedge clk) begin
        if (MemWrite) dmem[DataAdr[DAW+1:2]] <= WriteData;
    end
`endif

    always_ff @(posedge clk) begin
        if (reg_write) rf[rd] <= result;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc   <= '0;
            nzcv <= '0;
        end else begin
            pc <= take_branch ? alu_result : pc_plus4;
            if (flag_write) nzcv <= alu_flags;
        end
    end

endmodule

// File: tb/tb_cpu_top.sv
// Scoreboard bench for cpu_top: a directed program is backdoor-loaded into the ROM,
// expected stores are queued up front and a monitor matches every MemWrite against them.
module tb_cpu_top;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] WriteData, DataAdr;
    logic        MemWrite;

    cpu_top dut (
        .clk       (clk),
        .reset     (reset),
        .WriteData (WriteData),
        .DataAdr   (DataAdr),
        .MemWrite  (MemWrite)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
    } store_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          running  = 1'b0;
    store_t      exp_q[$];
    logic [31:0] adr_exp[bit [31:0]];
    logic [31:0] prog[$];

    localparam logic [3:0] EQ = 4'h0, NE = 4'h1, CS = 4'h2, VS = 4'h6;
    localparam logic [3:0] GE = 4'ha, LT = 4'hb, AL = 4'he;
    localparam logic [31:0] END_PC = 32'd148;

    function automatic logic [31:0] dp(input logic [3:0] c, input logic i, input logic [3:0] cmd,
                                       input logic s, input logic [3:0] rn, input logic [3:0] rd,
                                       input logic [11:0] op2);
        return {c, 2'b00, i, cmd, s, rn, rd, op2};
    endfunction

    function automatic logic [31:0] mem(input logic [3:0] c, input logic u, input logic l,
                                        input logic [3:0] rn, input logic [3:0] rd,
                                        input logic [11:0] imm);
        return {c, 2'b01, 1'b0, 1'b1, u, 1'b0, 1'b0, l, rn, rd, imm};
    endfunction

    function automatic logic [31:0] br(input logic [3:0] c, input logic [23:0] imm);
        return {c, 3'b101, 1'b0, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h, required %08h", name, act, req);
        end
    endtask

    task automatic expect_store(input logic [31:0] adr, input logic [31:0] data);
        store_t s;
        s.adr  = adr;
        s.data = data;
        exp_q.push_back(s);
    endtask

    // Monitor: per-cycle DataAdr spot checks and in-order store matching.
    initial begin
        store_t s;
        forever begin
            @(negedge clk);
            if (running) begin
                if (adr_exp.exists(dut.pc))
                    check($sformatf("adr_pc%0d", dut.pc), DataAdr, adr_exp[dut.pc]);
                if (MemWrite) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_store: adr %08h data %08h, required no store",
                                 DataAdr, WriteData);
                    end else begin
                        s = exp_q.pop_front();
                        check("store_adr", DataAdr, s.adr);
                        check($sformatf("store_data@%0d", s.adr), WriteData, s.data);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        #1;
        prog.push_back(dp(AL, 1'b0, 4'b0010, 1'b0, 4'd15, 4'd0, 12'h00F));  //   0 SUB R0,R15,R15
        prog.push_back(dp(AL, 1'b1, 4'b0100, 1'b0, 4'd0, 4'd1, 12'h007));   //   4 ADD R1,R0,#7
        prog.push_back(mem(AL, 1'b1, 1'b0, 4'd0, 4'd1, 12'd100));           //   8 STR R1,[R0,#100]
        prog.push_back(dp(AL, 1'b1, 4'b0100, 1'b0, 4'd0, 4'd9, 12'hC12));   //  12 ADD R9,R0,#0x1200
        prog.push_back(dp(AL, 1'b1, 4'b0100, 1'b0, 4'd9, 4'd9, 12'h034));   //  16 ADD R9,R9,#0x34
        prog.push_back(mem(AL, 1'b1, 1'b0, 4'd0, 4'd9, 12'd96));            //  20 STR R9,[R0,#96]
        prog.push_back(mem(AL, 1'b1, 1'b1, 4'd0, 4'd2, 12'd96));            //  24 LDR R2,[R0,#96]
        prog.push_back(mem(AL, 1'b1, 1'b0, 4'd0, 4'd2, 12'd100));           //  28 STR R2,[R0,#100]
        prog.push_back(dp(AL, 1'b1, 4'b0100, 1'b0, 4'd0, 4'd3, 12'h005));   //  32 ADD R3,R0,#5
        prog.push_back(dp(AL, 1'b0, 4'b0010, 1'b1, 4'd1, 4'd2, 12'h001));   //  36 SUBS R2,R1,R1
        prog.push_back(dp(NE, 1'b1, 4'b0100, 1'b0, 4'd0, 4'd3, 12'h001));   //  40 ADDNE R3,R0,#1
        prog.push_back(mem(AL, 1'b1, 1'b0, 4'd0, 4'd3, 12'd88));            //  44 STR R3,[R0,#88]
        prog.push_back(dp(EQ, 1'b1, 4'b0100, 1'b0, 4'd0, 4'd3, 12'h002));   //  48 ADDEQ R3,R0,#2
        prog.push_back(mem(AL, 1'b1, 1'b0, 4'd0, 4'd3, 12'd88));            //  52 STR R3,[R0,#88]
        prog.push_back(br(AL, 24'd0));                                      //  56 B +1 word
        prog.push_back(mem(AL, 1'b1, 1'b0, 4'd0, 4'd1, 12'd104));           //  60 STR R1,[R0,#104]
        prog.push_back(mem(AL, 1'b1, 1'b0, 4'd0, 4'd1, 12'd100));           //  64 STR R1,[R0,#100]
        prog.push_back(dp(AL, 1'b1, 4'b0100, 1'b0, 4'd0, 4'd4, 12'h4FF));   //  68 ADD R4,R0,#0xFF ror 8
        prog.push_back(mem(AL, 1'b1, 1'b0, 4'd0, 4'd4, 12'd92));            //  72 STR R4,[R0,#92]
        prog.push_back(dp(AL, 1'b0, 4'b0010, 1'b1, 4'd0, 4'd5, 12'h001));   //  76 SUBS R5,R0,R1
        prog.push_back(dp(LT, 1'b1, 4'b0100, 1'b0, 4'd0, 4'd6, 12'h009));   //  80 ADDLT R6,R0,#9
        prog.push_back(dp(CS, 1'b1, 4'b0100, 1'b0, 4'd0, 4'd6, 12'h003));   //  84 ADDCS R6,R0,#3
        prog.push_back(mem(AL, 1'b1, 1'b0, 4'd0, 4'd6, 12'd84));            //  88 STR R6,[R0,#84]
        prog.push_back(dp(AL, 1'b1, 4'b1100, 1'b0, 4'd1, 4'd7, 12'h030));   //  92 ORR R7,R1,#0x30
        prog.push_back(dp(AL, 1'b0, 4'b0000, 1'b0, 4'd7, 4'd8, 12'h001));   //  96 AND R8,R7,R1
        prog.push_back(mem(AL, 1'b1, 1'b0, 4'd0, 4'd7, 12'd80));            // 100 STR R7,[R0,#80]
        prog.push_back(mem(AL, 1'b1, 1'b0, 4'd0, 4'd8, 12'd76));            // 104 STR R8,[R0,#76]
        prog.push_back(br(EQ, 24'd0));                                      // 108 BEQ (not taken)
        prog.push_back(mem(AL, 1'b1, 1'b0, 4'd0, 4'd1, 12'd72));            // 112 STR R1,[R0,#72]
        prog.push_back(mem(AL, 1'b0, 1'b0, 4'd1, 4'd7, 12'd3));             // 116 STR R7,[R1,#-3]
        prog.push_back(dp(AL, 1'b1, 4'b0100, 1'b0, 4'd0, 4'd11, 12'h47F));  // 120 ADD R11,R0,#0x7F000000
        prog.push_back(dp(AL, 1'b0, 4'b0100, 1'b1, 4'd11, 4'd12, 12'h00B)); // 124 ADDS R12,R11,R11
        prog.push_back(mem(VS, 1'b1, 1'b0, 4'd0, 4'd12, 12'd68));           // 128 STRVS R12,[R0,#68]
        prog.push_back(mem(CS, 1'b1, 1'b0, 4'd0, 4'd1, 12'd108));           // 132 STRCS R1,[R0,#108]
        prog.push_back(mem(GE, 1'b1, 1'b0, 4'd0, 4'd1, 12'd64));            // 136 STRGE R1,[R0,#64]
        prog.push_back(dp(AL, 1'b1, 4'b1101, 1'b0, 4'd0, 4'd1, 12'h000));   // 140 MOV R1,#0 (unsupported)
        prog.push_back(mem(AL, 1'b1, 1'b0, 4'd0, 4'd1, 12'd60));            // 144 STR R1,[R0,#60]
        prog.push_back(br(AL, 24'hFFFFFE));                                 // 148 B .

        for (int i = 0; i < 64; i++)
            dut.imem[i] = (i < prog.size()) ? prog[i] : br(AL, 24'hFFFFFE);
        // A store sits at address 0 while reset is held; it must not strobe.
        dut.imem[0] = mem(AL, 1'b1, 1'b0, 4'd15, 4'd15, 12'd0);

        expect_store(32'd100, 32'd7);
        expect_store(32'd96,  32'h0000_1234);
        expect_store(32'd100, 32'h0000_1234);
        expect_store(32'd88,  32'd5);
        expect_store(32'd88,  32'd2);
        expect_store(32'd100, 32'd7);
        expect_store(32'd92,  32'hFF00_0000);
        expect_store(32'd84,  32'd9);
        expect_store(32'd80,  32'h0000_0037);
        expect_store(32'd76,  32'd7);
        expect_store(32'd72,  32'd7);
        expect_store(32'd4,   32'h0000_0037);
        expect_store(32'd68,  32'hFE00_0000);
        expect_store(32'd64,  32'd7);
        expect_store(32'd60,  32'd7);

        adr_exp[32'd0]   = 32'd0;
        adr_exp[32'd24]  = 32'd96;
        adr_exp[32'd56]  = 32'd64;
        adr_exp[32'd68]  = 32'hFF00_0000;
        adr_exp[32'd124] = 32'hFE00_0000;

        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_pc", dut.pc, 32'd0);
            check("reset_memwrite", {31'd0, MemWrite}, 32'd0);
        end
        dut.imem[0] = prog[0];
        reset   = 1'b1;
        running = 1'b1;

        for (int c = 0; c < 400 && dut.pc != END_PC; c++) @(negedge clk);
        if (dut.pc != END_PC) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: pc %08h, required %08h", dut.pc, END_PC);
        end
        repeat (4) @(negedge clk);
        running = 1'b0;
        check("stores_outstanding", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
